// File: rtl/offset_fifo_reader_pkg.sv
// rtl/offset_fifo_reader_pkg.sv - shared defaults and width helpers for the offset FIFO reader
package offset_fifo_reader_pkg;

  localparam int DEF_WIDTH  = 10;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_OFFSET = 1;

  localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W = DEF_PTR_W + 1;

  // Count needs one more bit than the pointers so "full" is distinguishable from "empty".
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/offset_fifo_reader_mem.sv
// rtl/offset_fifo_reader_mem.sv - FIFO storage, one write port and one asynchronous read port
module offset_fifo_mem
  import offset_fifo_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/offset_fifo_reader.sv
// rtl/offset_fifo_reader.sv - FIFO whose read side presents head+OFFSET and head+OFFSET+1
module offset_fifo_reader
  import offset_fifo_reader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int OFFSET = DEF_OFFSET
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic [WIDTH-1:0]         o_data2,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0] OFF_C   = WIDTH'(OFFSET);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data;
  logic             push;
  logic             pop;

  // Handshakes depend only on registered count, so i_ready never reaches o_ready.
  assign o_ready = (count_q < DEPTH_C);
  assign o_valid = (count_q != '0);
  assign o_count = count_q;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  offset_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push && i_rst_n),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_data)
  );

  // Sums wrap modulo 2^WIDTH; outputs are forced to zero while empty.
  always_comb begin : offset_math
    logic [WIDTH-1:0] sum1;
    logic [WIDTH-1:0] sum2;
    sum1    = rd_data + OFF_C;
    sum2    = sum1 + WIDTH'(1);
    o_data  = o_valid ? sum1 : '0;
    o_data2 = o_valid ? sum2 : '0;
  end

endmodule

// File: tb/tb_offset_fifo_reader.sv
// tb/tb_offset_fifo_reader.sv - scoreboard bench for offset_fifo_reader
module tb_offset_fifo_reader;

  localparam int WIDTH  = 10;
  localparam int DEPTH  = 4;
  localparam int OFFSET = 1;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] i_data = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic [WIDTH-1:0] o_data2;
  logic [$clog2(DEPTH):0] o_count;

  always #5 clk = ~clk;

  offset_fifo_reader #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .OFFSET (OFFSET)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_data2 (o_data2),
    .o_count (o_count)
  );

  logic [WIDTH-1:0] sb_q [$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon_en   = 1'b0;
  bit  pend_rst = 1'b1;
  bit  pend_push = 1'b0;
  logic [WIDTH-1:0] pend_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the reference queue is updated at the edge the DUT would act on.
  task automatic cyc(input bit v, input bit r, input logic [WIDTH-1:0] d, input bit rst);
    @(posedge clk);
    if (pend_rst) sb_q.delete();
    else if (pend_push) sb_q.push_back(pend_data);
    #1;
    i_valid   = v;
    i_ready   = r;
    i_data    = d;
    i_rst_n   = !rst;
    pend_rst  = rst;
    pend_push = v && !rst && (sb_q.size() < DEPTH);
    pend_data = d;
  endtask

  initial begin : monitor
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("count", int'(o_count), sb_q.size());
        chk("valid", int'(o_valid), int'(sb_q.size() != 0));
        chk("ready", int'(o_ready), int'(sb_q.size() < DEPTH));
        if (sb_q.size() != 0) begin
          e1 = sb_q[0] + WIDTH'(OFFSET);
          e2 = e1 + WIDTH'(1);
        end else begin
          e1 = '0;
          e2 = '0;
        end
        chk("data", int'(o_data), int'(e1));
        chk("data2", int'(o_data2), int'(e2));
        if (i_rst_n && i_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    cyc(0, 0, '0, 1);
    mon_en = 1'b1;
    cyc(0, 0, '0, 0);
    // basic offset and modulo wrap
    cyc(1, 0, 10'h005, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 1, '0, 0);
    cyc(1, 0, 10'h3FF, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 1, '0, 0);
    cyc(1, 0, 10'h3FE, 0);
    cyc(0, 1, '0, 0);
    // fill, hold off a fifth push, drain
    for (int i = 0; i < 5; i++) cyc(1, 0, WIDTH'(10'h100 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, '0, 0);
    // full with push and pop together
    for (int i = 0; i < 4; i++) cyc(1, 0, WIDTH'(10'h200 + i), 0);
    cyc(1, 1, 10'h2AA, 0);
    cyc(0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, '0, 0);
    // steady count 2 with concurrent traffic, pointers wrap
    cyc(1, 0, 10'h011, 0);
    cyc(1, 0, 10'h022, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, WIDTH'($urandom), 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, '0, 0);
    // reset while holding words, with a push attempted during reset
    for (int i = 0; i < 3; i++) cyc(1, 0, WIDTH'(10'h0F0 + i), 0);
    cyc(1, 0, 10'h0FF, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, '0, 0);
    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc(bit'($urandom_range(0, 99) < 60), bit'($urandom_range(0, 99) < 50),
          WIDTH'($urandom), ($urandom_range(0, 79) == 0));
    end
    cyc(0, 1, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, '0, 0);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
